guess_sender: RTL and testbench

GUESS_SENDER -- requirements
Module: guess_sender

---
 rtl/key_pkg.sv | 37 +++
 rtl/cycle_timer.sv | 35 +++
 rtl/guess_sender.sv | 185 ++++++++++++++++++
 tb/tb_guess_sender.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the guess sender and the checker it drives:
// sender FSM states, symbol-to-button mapping and checker state constants.
package key_pkg;

    // Sender FSM states
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESS       = 3'd1,
        ST_RELEASE     = 3'd2,
        ST_WAIT_RESULT = 3'd3,
        ST_DONE        = 3'd4
    } sender_state_t;

    // Checker states, kept here so both sides agree on the encoding
    typedef enum logic [1:0] {
        CHK_IDLE    = 2'd0,
        CHK_COLLECT = 2'd1,
        CHK_SUCCESS = 2'd2,
        CHK_FAIL    = 2'd3
    } checker_state_t;

    // Symbol 3 has no button; it aborts the sequence
    localparam logic [1:0] SYM_INVALID = 2'd3;

    // One-hot button for a symbol; the invalid symbol maps to no button
    function automatic logic [2:0] symbol_to_btn(input logic [1:0] sym);
        logic [2:0] btn;
        case (sym)
            2'd0:    btn = 3'b001;
            2'd1:    btn = 3'b010;
            2'd2:    btn = 3'b100;
            default: btn = 3'b000;
        endcase
        return btn;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Load/decrement duration counter. Loading N-1 makes expire fire on the
// N-th cycle after the load; expire is a single-cycle pulse.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count_reg;
    logic             armed_reg;

    // Count down after a load; disarm once the terminal count has been seen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            armed_reg <= 1'b0;
        end else if (load) begin
            count_reg <= load_value;
            armed_reg <= 1'b1;
        end else if (armed_reg) begin
            if (count_reg == '0) begin
                armed_reg <= 1'b0;
            end else begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign expire = armed_reg && (count_reg == '0);

endmodule

// File: rtl/guess_sender.sv
// Plays a four-symbol guess into the checker as timed button presses, then
// waits (bounded) for the checker's verdict and reports outcome and latency.
module guess_sender
    import key_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 50_000_000,
    parameter int PRESS_US       = 2_000,
    parameter int RELEASE_US     = 2_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  guess,
    output logic [2:0]  btn_out,
    input  logic        success_in,
    input  logic        fail_in,
    output logic        busy,
    output logic        done,
    output logic        result_ok,
    output logic        result_fail,
    output logic        timeout,
    output logic        bad_symbol,
    output logic [31:0] latency
);

    localparam int PRESS_CYCLES   = CLK_FREQUENCY / 1_000_000 * PRESS_US;
    localparam int RELEASE_CYCLES = CLK_FREQUENCY / 1_000_000 * RELEASE_US;
    localparam int MAX_CYCLES     = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int TIMER_W        = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

    localparam logic [TIMER_W-1:0] PRESS_LOAD   = TIMER_W'(PRESS_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RELEASE_LOAD = TIMER_W'(RELEASE_CYCLES - 1);
    localparam logic [31:0]        TIMEOUT_LIM  = 32'(TIMEOUT_CYCLES);

    sender_state_t state_reg, state_next;
    logic [1:0]    idx_reg, idx_next;
    logic [7:0]    guess_reg, guess_next;
    logic [2:0]    btn_reg, btn_next;
    logic          ok_reg, ok_next;
    logic          fail_reg, fail_next;
    logic          timeout_reg, timeout_next;
    logic          bad_reg, bad_next;
    logic [31:0]   latency_reg, latency_next;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expire;
    logic               press_req;
    logic [1:0]         press_sym;
    logic [1:0]         idx_inc;

    assign idx_inc = idx_reg + 2'd1;

    cycle_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .expire     (timer_expire)
    );

    // State and output registers; reset clears everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= 2'd0;
            guess_reg   <= 8'd0;
            btn_reg     <= 3'd0;
            ok_reg      <= 1'b0;
            fail_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            bad_reg     <= 1'b0;
            latency_reg <= 32'd0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            guess_reg   <= guess_next;
            btn_reg     <= btn_next;
            ok_reg      <= ok_next;
            fail_reg    <= fail_next;
            timeout_reg <= timeout_next;
            bad_reg     <= bad_next;
            latency_reg <= latency_next;
        end
    end

    // Next-state logic; a press request is resolved after the case so that
    // both start and end-of-release share the invalid-symbol handling
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        guess_next   = guess_reg;
        btn_next     = btn_reg;
        ok_next      = ok_reg;
        fail_next    = fail_reg;
        timeout_next = timeout_reg;
        bad_next     = bad_reg;
        latency_next = latency_reg;
        timer_load   = 1'b0;
        timer_value  = PRESS_LOAD;
        press_req    = 1'b0;
        press_sym    = 2'd0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    guess_next   = guess;
                    ok_next      = 1'b0;
                    fail_next    = 1'b0;
                    timeout_next = 1'b0;
                    bad_next     = 1'b0;
                    latency_next = 32'd0;
                    idx_next     = 2'd0;
                    press_req    = 1'b1;
                    press_sym    = guess[1:0];
                end
            end
            ST_PRESS: begin
                if (timer_expire) begin
                    btn_next    = 3'd0;
                    timer_load  = 1'b1;
                    timer_value = RELEASE_LOAD;
                    state_next  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (timer_expire) begin
                    idx_next = idx_inc;
                    if (idx_reg == 2'd3) begin
                        latency_next = 32'd0;
                        state_next   = ST_WAIT_RESULT;
                    end else begin
                        press_req = 1'b1;
                        press_sym = guess_reg[{idx_inc, 1'b0} +: 2];
                    end
                end
            end
            ST_WAIT_RESULT: begin
                if (success_in || fail_in) begin
                    ok_next    = success_in;
                    fail_next  = fail_in & ~success_in;
                    state_next = ST_DONE;
                end else if ((latency_reg + 32'd1) >= TIMEOUT_LIM) begin
                    latency_next = TIMEOUT_LIM;
                    timeout_next = 1'b1;
                    state_next   = ST_DONE;
                end else begin
                    latency_next = latency_reg + 32'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (press_req) begin
            if (press_sym == SYM_INVALID) begin
                bad_next   = 1'b1;
                btn_next   = 3'd0;
                state_next = ST_DONE;
            end else begin
                btn_next    = symbol_to_btn(press_sym);
                timer_load  = 1'b1;
                timer_value = PRESS_LOAD;
                state_next  = ST_PRESS;
            end
        end
    end

    assign btn_out     = btn_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign done        = (state_reg == ST_DONE);
    assign result_ok   = ok_reg;
    assign result_fail = fail_reg;
    assign timeout     = timeout_reg;
    assign bad_symbol  = bad_reg;
    assign latency     = latency_reg;

endmodule

// File: tb/tb_guess_sender.sv
// Directed bench for guess_sender with short press/release/timeout values.
module tb_guess_sender;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  guess = 8'd0;
    logic [2:0]  btn_out;
    logic        success_in = 1'b0;
    logic        fail_in = 1'b0;
    logic        busy;
    logic        done;
    logic        result_ok;
    logic        result_fail;
    logic        timeout;
    logic        bad_symbol;
    logic [31:0] latency;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    guess_sender #(
        .CLK_FREQUENCY  (1_000_000),
        .PRESS_US       (4),
        .RELEASE_US     (3),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .start       (start),
        .guess       (guess),
        .btn_out     (btn_out),
        .success_in  (success_in),
        .fail_in     (fail_in),
        .busy        (busy),
        .done        (done),
        .result_ok   (result_ok),
        .result_fail (result_fail),
        .timeout     (timeout),
        .bad_symbol  (bad_symbol),
        .latency     (latency)
    );

    typedef struct {
        logic [2:0] btn;
        int         cycles;
    } seg_t;

    typedef struct {
        logic s;
        logic f;
        int   delay;      // WAIT cycles before raising the verdict, -1 = never
        int   exp_ticks;  // edges from WAIT entry until done is seen
        logic ok;
        logic fl;
        logic to;
        int   lat;
    } vrow_t;

    seg_t  segs[8];
    vrow_t vrows[4];

    localparam logic [7:0] MAIN_GUESS = 8'b10_01_00_10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_start(input logic [7:0] g);
        start = 1'b1;
        guess = g;
        tick();
        start = 1'b0;
        guess = 8'd0;
    endtask

    // Walk the expected press/release pattern cycle by cycle; optionally pulse
    // a competing start in the middle, which must be ignored
    task automatic check_press_seq(input bit inject);
        int n;
        n = 0;
        foreach (segs[s]) begin
            for (int c = 0; c < segs[s].cycles; c++) begin
                check($sformatf("btn seg%0d cyc%0d", s, c), {29'd0, btn_out}, {29'd0, segs[s].btn});
                check("busy in sequence", {31'd0, busy}, 32'd1);
                if (inject && n == 5) begin
                    start = 1'b1;
                    guess = 8'hFF;
                end
                tick();
                start = 1'b0;
                guess = 8'd0;
                n++;
            end
        end
    endtask

    initial begin
        int  n;
        bit  seen;

        segs[0] = '{3'b100, 4}; segs[1] = '{3'b000, 3};
        segs[2] = '{3'b001, 4}; segs[3] = '{3'b000, 3};
        segs[4] = '{3'b010, 4}; segs[5] = '{3'b000, 3};
        segs[6] = '{3'b100, 4}; segs[7] = '{3'b000, 3};

        vrows[0] = '{1'b1, 1'b0,  7,  8, 1'b1, 1'b0, 1'b0,  7};
        vrows[1] = '{1'b1, 1'b1,  3,  4, 1'b1, 1'b0, 1'b0,  3};
        vrows[2] = '{1'b0, 1'b1,  0,  1, 1'b0, 1'b1, 1'b0,  0};
        vrows[3] = '{1'b0, 1'b0, -1, 50, 1'b0, 1'b0, 1'b1, 50};

        // Reset state
        #23;
        check("reset btn", {29'd0, btn_out}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset flags", {28'd0, result_ok, result_fail, timeout, bad_symbol}, 32'd0);
        check("reset latency", latency, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle after reset btn", {29'd0, btn_out}, 32'd0);
            check("idle after reset busy", {31'd0, busy}, 32'd0);
        end

        // Reset asserted mid-press clears the button immediately
        send_start(MAIN_GUESS);
        tick();
        check("press before reset", {29'd0, btn_out}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset btn", {29'd0, btn_out}, 32'd0);
        check("async reset busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("quiet after reset btn", {29'd0, btn_out}, 32'd0);
            check("quiet after reset busy", {31'd0, busy}, 32'd0);
        end

        // Verdict table: full clean sequence, then WAIT_RESULT behaviour
        foreach (vrows[r]) begin
            send_start(MAIN_GUESS);
            check("start clears ok", {31'd0, result_ok}, 32'd0);
            check("start clears timeout", {31'd0, timeout}, 32'd0);
            check_press_seq(r == 0);
            check("wait entry latency", latency, 32'd0);
            check("wait entry btn", {29'd0, btn_out}, 32'd0);
            n = 0;
            seen = 0;
            while (n < 60 && !seen) begin
                if (n == vrows[r].delay) begin
                    success_in = vrows[r].s;
                    fail_in    = vrows[r].f;
                end
                tick();
                n++;
                if (done) seen = 1;
            end
            success_in = 1'b0;
            fail_in    = 1'b0;
            check($sformatf("row%0d cycles to done", r), n, vrows[r].exp_ticks);
            check($sformatf("row%0d done", r), {31'd0, done}, 32'd1);
            check($sformatf("row%0d result_ok", r), {31'd0, result_ok}, {31'd0, vrows[r].ok});
            check($sformatf("row%0d result_fail", r), {31'd0, result_fail}, {31'd0, vrows[r].fl});
            check($sformatf("row%0d timeout", r), {31'd0, timeout}, {31'd0, vrows[r].to});
            check($sformatf("row%0d bad_symbol", r), {31'd0, bad_symbol}, 32'd0);
            check($sformatf("row%0d latency", r), latency, vrows[r].lat);
            tick();
            check($sformatf("row%0d done one cycle", r), {31'd0, done}, 32'd0);
            check($sformatf("row%0d idle busy", r), {31'd0, busy}, 32'd0);
            check($sformatf("row%0d ok held", r), {31'd0, result_ok}, {31'd0, vrows[r].ok});
            check($sformatf("row%0d latency held", r), latency, vrows[r].lat);
        end

        // Invalid second symbol; a success level outside WAIT_RESULT is ignored
        success_in = 1'b1;
        send_start(8'b00_00_11_00);
        for (int c = 0; c < 7; c++) begin
            check($sformatf("bad seq btn cyc%0d", c), {29'd0, btn_out}, (c < 4) ? 32'd1 : 32'd0);
            tick();
        end
        check("bad done", {31'd0, done}, 32'd1);
        check("bad bad_symbol", {31'd0, bad_symbol}, 32'd1);
        check("bad result_ok", {31'd0, result_ok}, 32'd0);
        check("bad btn", {29'd0, btn_out}, 32'd0);
        success_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bad no second press", {29'd0, btn_out}, 32'd0);
            check("bad idle busy", {31'd0, busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
